deserializer_rx: RTL and testbench
==================================

DESERIALIZER_RX -- requirements
Module: deserializer_rx

Interface
REQ-001 Parameter DATA_BUS_WIDTH, default 16, parallel word width W.
REQ-002 Parameter DATA_MOD_WIDTH, default 4, width of bit-count field; SHALL equal $clog2(DATA_BUS_WIDTH).
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 arst_ni  in  1  reset, asynchronous, active-low.
REQ-005 ser_data_i  in  1  serial data bit, MSB of word first.
REQ-006 ser_data_val_i  in  1  qualifies ser_data_i and ser_last_i.
REQ-007 ser_last_i  in  1  marks final bit of a short word; ignored when ser_data_val_i=0.
REQ-008 deser_data_o  out  W  assembled word, left-aligned, unfilled LSBs 0.
REQ-009 deser_mod_o  out  DATA_MOD_WIDTH  valid bit count; 0 encodes W bits.
REQ-010 deser_data_val_o  out  1  output word valid.
REQ-011 deser_data_rdy_i  in  1  consumer ready; transfer when val=1 and rdy=1.
REQ-012 busy_o  out  1  partial word being assembled.
REQ-013 overflow_o  out  1  sticky: a completed word was dropped.

Function
REQ-014 Collector holds bit counter cnt (0..W-1) and W-bit accumulator; bit accepted when ser_data_val_i=1.
REQ-015 Accepted bit SHALL be written to accumulator index W-1-cnt; cnt increments.
REQ-016 Completion: accepted bit with cnt=W-1, or accepted bit with ser_last_i=1 (any cnt).
REQ-017 On completion, word SHALL go to output register the next cycle (latency 1 from final bit) with deser_mod_o=(cnt+1) mod W.
REQ-018 On completion, cnt and accumulator SHALL clear in the same edge; next word's first bit is accepted in the following cycle with no dead cycle.
REQ-019 ser_last_i at cnt=W-1 SHALL be treated as a single completion, mod=0.
REQ-020 Output register states: EMPTY (val=0), FULL (val=1); EMPTY->FULL on completion; FULL->EMPTY on transfer without completion; FULL->FULL on transfer with coincident completion (new word loaded).
REQ-021 While FULL and not transferring, deser_data_o and deser_mod_o SHALL be held stable.
REQ-022 Completion while FULL and rdy=0: new word dropped, held word unchanged, overflow_o set to 1 next cycle.
REQ-023 overflow_o SHALL clear only on reset.
REQ-024 Collector SHALL keep accepting bits regardless of output state (no backpressure to serial side).
REQ-025 busy_o SHALL be 1 exactly when cnt!=0, registered.
REQ-026 Gaps (ser_data_val_i=0) mid-word SHALL not alter cnt or accumulator.
REQ-027 deser_data_o SHALL be 0 when EMPTY.

Reset
REQ-028 arst_ni=0 SHALL immediately force deser_data_o=0, deser_mod_o=0, deser_data_val_o=0, busy_o=0, overflow_o=0, cnt=0, accumulator=0.
REQ-029 A partial word in progress at reset SHALL be discarded; no output word after deassertion.
REQ-030 First bit SHALL be accepted on the first rising edge after arst_ni deasserts with ser_data_val_i=1.

Verification
REQ-031 16 bits of 0xA5C3 MSB-first contiguous, rdy=1 -> one cycle after 16th bit: data=0xA5C3, mod=0, val high 1 cycle, busy 1 during bits 2..16 window.
REQ-032 Bits 1,0,1,1,0 with ser_last_i on 5th -> data=0xB000, mod=5, val 1 cycle.
REQ-033 0xA5C3 with random val=0 gaps inserted -> identical output to REQ-031, no extra val pulses.
REQ-034 rdy=0, words 0x1234 then 0xFFFF -> output holds 0x1234, overflow=1; raise rdy -> 0x1234 transferred, val drops, overflow stays 1.
REQ-035 Back-to-back full words 0x0001, 0x8000 with rdy toggled to transfer on second completion edge -> both delivered in order, overflow=0.
REQ-036 arst_ni low after 7 bits of a word -> all outputs 0 immediately; then 16 bits of 0x5A5A -> data=0x5A5A, mod=0.

Source files
------------

// File: rtl/deserializer_rx.sv
// Serial-to-parallel receiver: MSB-first bits into a left-aligned word, output 1 cycle after the final bit.
// No backpressure to the serial side: a word completing while the output is held and not taken is dropped (sticky overflow).
module deserializer_rx #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    input  logic                      ser_last_i,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic [DATA_MOD_WIDTH-1:0] deser_mod_o,
    output logic                      deser_data_val_o,
    input  logic                      deser_data_rdy_i,
    output logic                      busy_o,
    output logic                      overflow_o
);

    localparam int W = DATA_BUS_WIDTH;
    localparam logic [DATA_MOD_WIDTH-1:0] LAST_IDX = DATA_MOD_WIDTH'(W - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [DATA_MOD_WIDTH-1:0] r_cnt;
    logic [DATA_MOD_WIDTH-1:0] w_cnt_nxt;
    logic [W-1:0]              r_acc;
    logic [W-1:0]              w_acc_nxt;
    logic [W-1:0]              r_data;
    logic [DATA_MOD_WIDTH-1:0] r_mod;
    logic                      r_busy;
    logic                      r_ovf;

    logic [W-1:0]              w_bit_mask;
    logic [W-1:0]              w_word;
    logic [DATA_MOD_WIDTH-1:0] w_mod;
    logic                      w_complete;
    logic                      w_xfer;
    logic                      w_load;
    logic                      w_clear;
    logic                      w_drop;

    // Word as it stands including the bit arriving this cycle; this is what gets loaded on completion.
    assign w_bit_mask = {{(W-1){1'b0}}, 1'b1} << (LAST_IDX - r_cnt);
    assign w_word     = ser_data_i ? (r_acc | w_bit_mask) : r_acc;
    assign w_complete = ser_data_val_i && ((r_cnt == LAST_IDX) || ser_last_i);
    assign w_mod      = (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
    assign w_xfer     = (r_state == ST_FULL) && deser_data_rdy_i;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_acc_nxt = r_acc;
        if (ser_data_val_i) begin
            if (w_complete) begin
                w_cnt_nxt = '0;
                w_acc_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
                w_acc_nxt = w_word;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_complete) begin
                    w_state_nxt = ST_FULL;
                    w_load      = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    if (w_complete) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                        w_clear     = 1'b1;
                    end
                end else if (w_complete) begin
                    w_drop = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= ST_EMPTY;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_mod   <= '0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_busy  <= (w_cnt_nxt != '0);
            r_ovf   <= r_ovf | w_drop;
            if (w_load) begin
                r_data <= w_word;
                r_mod  <= w_mod;
            end else if (w_clear) begin
                r_data <= '0;
                r_mod  <= '0;
            end
        end
    end

    assign deser_data_o     = r_data;
    assign deser_mod_o      = r_mod;
    assign deser_data_val_o = (r_state == ST_FULL);
    assign busy_o           = r_busy;
    assign overflow_o       = r_ovf;

endmodule

// File: tb/tb_deserializer_rx.sv
// Bench for deserializer_rx: directed scenarios plus random traffic against a bit-list reference model.
module tb_deserializer_rx;

    localparam int W  = 16;
    localparam int MW = 4;

    logic          clk_i            = 1'b0;
    logic          arst_ni          = 1'b0;
    logic          ser_data_i       = 1'b0;
    logic          ser_data_val_i   = 1'b0;
    logic          ser_last_i       = 1'b0;
    logic          deser_data_rdy_i = 1'b0;
    logic [W-1:0]  deser_data_o;
    logic [MW-1:0] deser_mod_o;
    logic          deser_data_val_o;
    logic          busy_o;
    logic          overflow_o;

    deserializer_rx #(
        .DATA_BUS_WIDTH (W),
        .DATA_MOD_WIDTH (MW)
    ) dut (
        .clk_i            (clk_i),
        .arst_ni          (arst_ni),
        .ser_data_i       (ser_data_i),
        .ser_data_val_i   (ser_data_val_i),
        .ser_last_i       (ser_last_i),
        .deser_data_o     (deser_data_o),
        .deser_mod_o      (deser_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .deser_data_rdy_i (deser_data_rdy_i),
        .busy_o           (busy_o),
        .overflow_o       (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the word in progress is just the list of bits received so far.
    bit            m_bits[$];
    logic          m_val  = 1'b0;
    logic [W-1:0]  m_data = '0;
    logic [MW-1:0] m_mod  = '0;
    logic          m_busy = 1'b0;
    logic          m_ovf  = 1'b0;

    logic [W-1:0]  got_data[$];
    logic [MW-1:0] got_mod[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_val  = 1'b0;
        m_data = '0;
        m_mod  = '0;
        m_busy = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_cycle(input logic d, input logic v, input logic l, input logic r);
        logic         xfer;
        logic         done;
        logic [W-1:0] word;
        int           nbits;
        xfer = m_val && r;
        done = 1'b0;
        word = '0;
        nbits = 0;
        if (v) begin
            m_bits.push_back(d);
            if (m_bits.size() == W || l) begin
                done  = 1'b1;
                nbits = m_bits.size();
                for (int i = 0; i < nbits; i++)
                    if (m_bits[i]) word = word | (W'(1) << (W - 1 - i));
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_val || xfer) begin
                m_val  = 1'b1;
                m_data = word;
                m_mod  = MW'(nbits % W);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (xfer) begin
            m_val  = 1'b0;
            m_data = '0;
        end
        m_busy = (m_bits.size() != 0);
    endtask

    // Called at a falling edge: check outputs, drive the next inputs, advance the model.
    task automatic step(input logic d, input logic v, input logic l, input logic r);
        check_eq("val", deser_data_val_o, m_val);
        check_eq("data", deser_data_o, m_data);
        if (m_val) check_eq("mod", deser_mod_o, m_mod);
        check_eq("busy", busy_o, m_busy);
        check_eq("ovf", overflow_o, m_ovf);
        ser_data_i       = d;
        ser_data_val_i   = v;
        ser_last_i       = l;
        deser_data_rdy_i = r;
        if (deser_data_val_o && r) begin
            got_data.push_back(deser_data_o);
            got_mod.push_back(deser_mod_o);
        end
        model_cycle(d, v, l, r);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'($urandom), 1'b0, 1'($urandom), r);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int n, input logic last_end,
                             input int gap_pct, input logic r, input logic r_final);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) step(1'($urandom), 1'b0, 1'($urandom), r);
            step(w[W-1-i], 1'b1, last_end && (i == n - 1), (i == n - 1) ? r_final : r);
        end
    endtask

    task automatic do_reset(input string tag);
        #2 arst_ni = 1'b0;
        #1;
        check_eq({tag, "_data"}, deser_data_o, '0);
        check_eq({tag, "_mod"}, deser_mod_o, '0);
        check_eq({tag, "_val"}, deser_data_val_o, 1'b0);
        check_eq({tag, "_busy"}, busy_o, 1'b0);
        check_eq({tag, "_ovf"}, overflow_o, 1'b0);
        model_reset();
        ser_data_val_i = 1'b0;
        ser_last_i     = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        arst_ni = 1'b1;
        got_data.delete();
        got_mod.delete();
    endtask

    task automatic check_delivered(input string tag, input int idx,
                                   input logic [W-1:0] d, input logic [MW-1:0] m);
        if (got_data.size() > idx) begin
            check_eq({tag, "_data"}, got_data[idx], d);
            check_eq({tag, "_mod"}, got_mod[idx], m);
        end else begin
            check_eq({tag, "_present"}, got_data.size(), idx + 1);
        end
    endtask

    initial begin
        @(negedge clk_i);
        check_eq("por_data", deser_data_o, '0);
        check_eq("por_val", deser_data_val_o, 1'b0);
        check_eq("por_busy", busy_o, 1'b0);
        check_eq("por_ovf", overflow_o, 1'b0);
        arst_ni = 1'b1;

        // Full word, contiguous
        send_word(16'hA5C3, W, 1'b0, 0, 1'b1, 1'b1);
        idle(3, 1'b1);
        check_eq("w31_count", got_data.size(), 1);
        check_delivered("w31", 0, 16'hA5C3, 4'd0);
        got_data.delete(); got_mod.delete();

        // Short word terminated by last
        send_word(16'hB000, 5, 1'b1, 0, 1'b1, 1'b1);
        idle(3, 1'b1);
        check_eq("w32_count", got_data.size(), 1);
        check_delivered("w32", 0, 16'hB000, 4'd5);
        got_data.delete(); got_mod.delete();

        // Full word with random gaps
        send_word(16'hA5C3, W, 1'b0, 40, 1'b1, 1'b1);
        idle(3, 1'b1);
        check_eq("w33_count", got_data.size(), 1);
        check_delivered("w33", 0, 16'hA5C3, 4'd0);
        got_data.delete(); got_mod.delete();

        // Held word while consumer stalls; second word dropped
        send_word(16'h1234, W, 1'b0, 0, 1'b0, 1'b0);
        send_word(16'hFFFF, W, 1'b0, 0, 1'b0, 1'b0);
        idle(2, 1'b0);
        check_eq("w34_hold", deser_data_o, 16'h1234);
        check_eq("w34_ovf_set", overflow_o, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        check_eq("w34_val_drop", deser_data_val_o, 1'b0);
        check_eq("w34_ovf_sticky", overflow_o, 1'b1);
        check_eq("w34_count", got_data.size(), 1);
        check_delivered("w34", 0, 16'h1234, 4'd0);

        // Back-to-back words, transfer coincides with second completion
        do_reset("rst35");
        send_word(16'h0001, W, 1'b0, 0, 1'b0, 1'b0);
        send_word(16'h8000, W, 1'b0, 0, 1'b0, 1'b1);
        idle(3, 1'b1);
        check_eq("w35_count", got_data.size(), 2);
        check_delivered("w35a", 0, 16'h0001, 4'd0);
        check_delivered("w35b", 1, 16'h8000, 4'd0);
        check_eq("w35_ovf", overflow_o, 1'b0);

        // Reset mid-word discards the partial word
        send_word(16'hFFFF, 7, 1'b0, 0, 1'b1, 1'b1);
        check_eq("w36_busy_pre", busy_o, 1'b1);
        do_reset("rst36");
        send_word(16'h5A5A, W, 1'b0, 0, 1'b1, 1'b1);
        idle(3, 1'b1);
        check_eq("w36_count", got_data.size(), 1);
        check_delivered("w36", 0, 16'h5A5A, 4'd0);

        // Random traffic
        do_reset("rst_rand");
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset("rst_mid");
            step(1'($urandom), $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 60);
        end
        idle(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
